// File: rtl/spi_host_xfer.sv
// spi_host_xfer: single-lane SPI mode-0 host running cmd/addr/[dummy]/data transfers.
module spi_host_xfer #(
  parameter int CLK_DIV      = 4,
  parameter int DUMMY_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_clk_o,
  output logic        spi_cs_o,
  output logic        spi_sdo0_o,
  input  logic        spi_sdi0_i
);
  localparam int BW = $clog2(73 + DUMMY_CYCLES);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_WR   = BW'(71);
  localparam logic [BW-1:0] LAST_RD   = BW'(71 + DUMMY_CYCLES);
  localparam logic [BW-1:0] CMD_END   = BW'(8);
  localparam logic [BW-1:0] ADDR_END  = BW'(40);
  localparam logic [BW-1:0] DUMMY_END = BW'(40 + DUMMY_CYCLES);
  typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD, CS_GAP} state_t;
  state_t state, nxt;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, n;
  logic [71:0] tx;
  logic [31:0] rx;
  logic rd, rose, tick, last;
  // n is the index of the bit that goes on the line at the next fall
  always_comb begin
    n = bit_cnt + 1'b1;
    tick = div_cnt == DIV_LAST;
    last = bit_cnt == (rd ? LAST_RD : LAST_WR);
    nxt = n < CMD_END ? CMD : n < ADDR_END ? ADDR : (rd && n < DUMMY_END) ? DUMMY : DATA;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b0;
      spi_cs_o <= 1'b1;
      spi_clk_o <= 1'b0;
      spi_sdo0_o <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rose <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rose <= 1'b0;
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      // rose marks the cycle spi_clk_o is first high; sdi is taken at its end
      if (rose && state == DATA) rx <= {rx[30:0], spi_sdi0_i};
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            state <= CS_SETUP;
            req_ready <= 1'b0;
            spi_cs_o <= 1'b0;
            spi_sdo0_o <= req_cmd[7];
            tx <= {req_cmd, req_addr, req_read ? 32'h0 : req_wdata};
            rd <= req_read;
            bit_cnt <= '0;
          end
        end
        CS_HOLD: if (tick) begin
          spi_cs_o <= 1'b1;
          rsp_valid <= 1'b1;
          if (rd) rsp_rdata <= rx;
          state <= CS_GAP;
        end
        CS_GAP: if (tick) begin
          state <= IDLE;
          req_ready <= 1'b1;
        end
        default: if (tick) begin
          if (!spi_clk_o) begin
            spi_clk_o <= 1'b1;
            rose <= 1'b1;
            if (state == CS_SETUP) state <= CMD;
          end else begin
            spi_clk_o <= 1'b0;
            bit_cnt <= n;
            tx <= {tx[70:0], 1'b0};
            spi_sdo0_o <= tx[70];
            state <= last ? CS_HOLD : nxt;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_host_xfer.sv
// tb_spi_host_xfer: directed checks of spi_host_xfer with a mode-0 slave model and protocol monitor.
module tb_spi_host_xfer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid[2], req_ready[2], req_read[2], rsp_valid[2], busy[2];
  logic sclk[2], cs[2], sdo[2], sdi[2];
  logic psclk[2], psdo[2], prdy[2], pcs[2];
  logic [7:0] req_cmd[2];
  logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2], rsp_data[2];
  logic [127:0] resp[2], cap[2], rsp_cap[2];
  int rises[2] = '{0, 0}, rsp_rises[2] = '{0, 0};
  int n_acc[2] = '{0, 0}, n_rsp[2] = '{0, 0}, viol[2] = '{0, 0};
  int t_acc[2] = '{0, 0}, t_prev[2] = '{0, 0}, t_rsp[2] = '{0, 0};
  int t_rdy[2] = '{0, 0}, t_csh[2] = '{0, 0}, t_csl[2] = '{0, 0};
  int cyc = 0, vecs = 0, errs = 0;

  spi_host_xfer #(.CLK_DIV(2), .DUMMY_CYCLES(32)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_read(req_read[0]), .req_cmd(req_cmd[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]), .spi_clk_o(sclk[0]),
    .spi_cs_o(cs[0]), .spi_sdo0_o(sdo[0]), .spi_sdi0_i(sdi[0]));
  spi_host_xfer #(.CLK_DIV(3), .DUMMY_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_read(req_read[1]), .req_cmd(req_cmd[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]), .spi_clk_o(sclk[1]),
    .spi_cs_o(cs[1]), .spi_sdo0_o(sdo[1]), .spi_sdi0_i(sdi[1]));

  always @(posedge clk) cyc <= cyc + 1;

  // slave drives resp bit k before rise k, changing only in fall cycles
  for (genvar g = 0; g < 2; g++) begin : mon
    always @(negedge clk) begin
      psclk[g] <= sclk[g];
      psdo[g] <= sdo[g];
      prdy[g] <= req_ready[g];
      pcs[g] <= cs[g];
      if (rst_n && req_valid[g] && req_ready[g]) begin
        n_acc[g] <= n_acc[g] + 1;
        t_prev[g] <= t_acc[g];
        t_acc[g] <= cyc;
        rises[g] <= 0;
        cap[g] <= '0;
      end else if (sclk[g] && !psclk[g]) begin
        rises[g] <= rises[g] + 1;
        cap[g] <= {cap[g][126:0], sdo[g]};
      end
      if (cs[g]) sdi[g] <= resp[g][127];
      else if (!sclk[g] && psclk[g]) sdi[g] <= resp[g][127 - rises[g]];
      if (rsp_valid[g]) begin
        n_rsp[g] <= n_rsp[g] + 1;
        t_rsp[g] <= cyc;
        rsp_cap[g] <= cap[g];
        rsp_rises[g] <= rises[g];
        rsp_data[g] <= rsp_rdata[g];
      end
      if (req_ready[g] && !prdy[g]) t_rdy[g] <= cyc;
      if (cs[g] && !pcs[g]) t_csh[g] <= cyc;
      if (!cs[g] && pcs[g]) t_csl[g] <= cyc;
      if ((sclk[g] && sdo[g] !== psdo[g]) || (cs[g] && sclk[g])) viol[g] <= viol[g] + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input int g, input logic rd, input logic [7:0] c, input logic [31:0] a,
                    input logic [31:0] w, input logic hold);
    int base;
    @(posedge clk);
    #1;
    req_valid[g] = 1'b1;
    req_read[g] = rd;
    req_cmd[g] = c;
    req_addr[g] = a;
    req_wdata[g] = w;
    base = n_acc[g];
    for (int i = 0; i < 1000 && n_acc[g] == base; i++) tick();
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid[g] = 1'b0;
      req_read[g] = ~rd;
      req_cmd[g] = 8'hFF;
      req_addr[g] = ~a;
      req_wdata[g] = ~w;
    end
  endtask

  task automatic wait_rsp(input int g, input int base);
    for (int i = 0; i < 2000 && n_rsp[g] == base; i++) tick();
  endtask

  task automatic wait_rdy(input int g);
    for (int i = 0; i < 2000 && !req_ready[g]; i++) tick();
  endtask

  initial begin
    int b, a;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0;
      req_read[g] = 1'b0;
      req_cmd[g] = 8'h0;
      req_addr[g] = 32'h0;
      req_wdata[g] = 32'h0;
      resp[g] = '0;
    end
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      chk("reset_pins", 128'({cs[g], sclk[g], sdo[g], rsp_valid[g], busy[g], req_ready[g]}), 128'b100000);
      chk("reset_rdata", 128'(rsp_rdata[g]), 128'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ready_before_edge", 128'(req_ready[0]), 128'h0);
    tick();
    chk("ready_after_edge", 128'(req_ready[0]), 128'h1);
    chk("ready_after_edge_u1", 128'(req_ready[1]), 128'h1);

    // write, CLK_DIV=2
    b = n_rsp[0];
    go(0, 1'b0, 8'h02, 32'h1A10_0000, 32'hDEAD_BEEF, 1'b0);
    wait_rsp(0, b);
    chk("wr_rsp_time", 128'(t_rsp[0] - t_acc[0]), 128'd291);
    wait_rdy(0);
    chk("wr_ready_time", 128'(t_rdy[0] - t_acc[0]), 128'd293);
    chk("wr_rises", 128'(rsp_rises[0]), 128'd72);
    chk("wr_bits", rsp_cap[0], {56'h0, 8'h02, 32'h1A10_0000, 32'hDEAD_BEEF});
    chk("wr_rdata_kept", 128'(rsp_rdata[0]), 128'h0);
    chk("wr_rsp_pulses", 128'(n_rsp[0] - b), 128'd1);

    // read, CLK_DIV=2, 32 dummy clocks
    resp[0] = 128'h1234_5678 << 24;
    b = n_rsp[0];
    go(0, 1'b1, 8'h0B, 32'h0000_0010, 32'h0, 1'b0);
    wait_rsp(0, b);
    chk("rd_rsp_time", 128'(t_rsp[0] - t_acc[0]), 128'd419);
    chk("rd_rdata", 128'(rsp_data[0]), 128'h1234_5678);
    wait_rdy(0);
    chk("rd_ready_time", 128'(t_rdy[0] - t_acc[0]), 128'd421);
    chk("rd_rises", 128'(rsp_rises[0]), 128'd104);
    chk("rd_bits", rsp_cap[0], {24'h0, 8'h0B, 32'h0000_0010, 64'h0});
    chk("rd_rdata_held", 128'(rsp_rdata[0]), 128'h1234_5678);

    // back-to-back writes with req_valid held; payload changes mid-transfer
    b = n_rsp[0];
    a = n_acc[0];
    go(0, 1'b0, 8'h02, 32'h0000_1000, 32'h1111_2222, 1'b1);
    req_addr[0] = 32'h0000_2000;
    req_wdata[0] = 32'h3333_4444;
    wait_rsp(0, b);
    chk("b2b_first_bits", rsp_cap[0], {56'h0, 8'h02, 32'h0000_1000, 32'h1111_2222});
    for (int i = 0; i < 100 && n_acc[0] != a + 2; i++) tick();
    chk("b2b_accept_gap", 128'(t_acc[0] - t_prev[0]), 128'd293);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    tick();
    chk("b2b_cs_high_gap", 128'((t_csl[0] - t_csh[0]) >= 2), 128'h1);
    wait_rsp(0, b + 1);
    chk("b2b_second_bits", rsp_cap[0], {56'h0, 8'h02, 32'h0000_2000, 32'h3333_4444});
    wait_rdy(0);
    chk("b2b_rdata_kept", 128'(rsp_rdata[0]), 128'h1234_5678);

    // reset pulse during the address phase
    b = n_rsp[0];
    go(0, 1'b0, 8'h02, 32'hCAFE_F00D, 32'h0123_4567, 1'b0);
    repeat (60) tick();
    chk("abort_busy_before", 128'(busy[0]), 128'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_pins", 128'({cs[0], sclk[0], busy[0]}), 128'b100);
    repeat (400) tick();
    chk("abort_no_rsp", 128'(n_rsp[0] - b), 128'd0);
    chk("abort_rdata", 128'(rsp_rdata[0]), 128'h0);
    go(0, 1'b0, 8'h02, 32'h0000_0004, 32'h55AA_33CC, 1'b0);
    wait_rsp(0, b);
    chk("post_abort_time", 128'(t_rsp[0] - t_acc[0]), 128'd291);
    chk("post_abort_bits", rsp_cap[0], {56'h0, 8'h02, 32'h0000_0004, 32'h55AA_33CC});
    wait_rdy(0);

    // read with no dummy clocks, CLK_DIV=3
    resp[1] = 128'hA5C3_0F96 << 56;
    b = n_rsp[1];
    go(1, 1'b1, 8'h0B, 32'h0000_0100, 32'h0, 1'b0);
    wait_rsp(1, b);
    chk("nodummy_rsp_time", 128'(t_rsp[1] - t_acc[1]), 128'd436);
    chk("nodummy_rdata", 128'(rsp_data[1]), 128'hA5C3_0F96);
    wait_rdy(1);
    chk("nodummy_ready_time", 128'(t_rdy[1] - t_acc[1]), 128'd439);
    chk("nodummy_rises", 128'(rsp_rises[1]), 128'd72);
    chk("nodummy_bits", rsp_cap[1], {56'h0, 8'h0B, 32'h0000_0100, 32'h0});

    chk("protocol_u0", 128'(viol[0]), 128'd0);
    chk("protocol_u1", 128'(viol[1]), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
